// File: rtl/prbs_capture_checker.sv
// PRBS checker: self-seeds from the captured stream, locks, then counts mismatches; drops lock on error bursts.
// All outputs are registered (one-edge latency); sample_valid=0 cycles freeze the model and every counter.
module prbs_capture_checker #(
  parameter int                LFSR_W      = 7,
  parameter logic [LFSR_W-1:0] TAPS        = 7'b1100000,
  parameter int                LOCK_CNT    = 8,
  parameter int                WINDOW      = 32,
  parameter int                LOSS_THRESH = 4,
  parameter int                ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             sample_valid,
  input  logic             sample_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  localparam int FILL_W  = $clog2(LFSR_W + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEED   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t             st;
  logic [LFSR_W-1:0]  s;
  logic [FILL_W-1:0]  fill;
  logic [MATCH_W-1:0] match;
  logic [WIN_W-1:0]   win_cnt;
  logic [WERR_W-1:0]  win_err;

  logic predicted;
  logic mismatch;
  logic err_hit;

  assign predicted = ^(s & TAPS);
  assign mismatch  = sample_in ^ predicted;
  assign err_hit   = en && (st == LOCKED) && sample_valid && mismatch;
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      s         <= '0;
      fill      <= '0;
      match     <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
    end else begin
      err_pulse <= err_hit;

      // clr wins over a coincident increment; the pulse above still fires
      if (clr)
        err_cnt <= '0;
      else if (err_hit && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      if (!en) begin
        st     <= IDLE;
        locked <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st    <= SEED;
            s     <= '0;
            fill  <= '0;
            match <= '0;
          end

          SEED: begin
            if (sample_valid) begin
              s <= {s[LFSR_W-2:0], sample_in};
              if (fill != FILL_W'(LFSR_W)) begin
                fill <= fill + 1'b1;
              end else if (mismatch) begin
                match <= '0;
              end else if (s != '0) begin
                // an all-zero register predicts zeros forever, so it never earns lock
                if (match == MATCH_W'(LOCK_CNT - 1)) begin
                  st      <= LOCKED;
                  locked  <= 1'b1;
                  match   <= '0;
                  win_cnt <= '0;
                  win_err <= '0;
                end else begin
                  match <= match + 1'b1;
                end
              end
            end
          end

          LOCKED: begin
            if (sample_valid) begin
              if (mismatch && (win_err == WERR_W'(LOSS_THRESH - 1))) begin
                st      <= SEED;
                locked  <= 1'b0;
                s       <= '0;
                fill    <= '0;
                match   <= '0;
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                s <= {s[LFSR_W-2:0], predicted};
                if (win_cnt == WIN_W'(WINDOW - 1)) begin
                  win_cnt <= '0;
                  win_err <= '0;
                end else begin
                  win_cnt <= win_cnt + 1'b1;
                  if (mismatch)
                    win_err <= win_err + 1'b1;
                end
              end
            end
          end

          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_capture_checker.sv
// Bench for prbs_capture_checker: table vectors plus scripted PRBS7 sequences, scoreboard-checked each edge.
module tb_prbs_capture_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clr, sample_valid, sample_in;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;
  logic        locked4, err_pulse4;
  logic [3:0]  err_cnt4;
  logic [1:0]  state4;

  prbs_capture_checker u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
  );

  prbs_capture_checker #(.ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .state(state4)
  );

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEED = 2'b01;
  localparam logic [1:0] ST_LOCK = 2'b10;

  int n_chk = 0;
  int n_err = 0;
  int exp16 = 0;
  int exp4  = 0;
  int wpos  = 0;
  int werr  = 0;
  logic [6:0] g = 7'h7F;

  typedef struct {
    logic [1:0] st;
    logic       lk;
    logic       pl;
    int         c16;
    int         c4;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic       en;
    logic       clr;
    logic       v;
    logic       b;
    logic [1:0] st;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic next_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic step(input logic v, input logic b, input logic c, input logic [1:0] e_st,
                      input logic e_lk, input logic e_pl, input string nm);
    sb_t e;
    sample_valid = v;
    sample_in    = b;
    clr          = c;
    if (c) begin
      exp16 = 0;
      exp4  = 0;
    end else if (e_pl) begin
      if (exp16 < 65535) exp16++;
      if (exp4 < 15) exp4++;
    end
    e.st = e_st; e.lk = e_lk; e.pl = e_pl; e.c16 = exp16; e.c4 = exp4;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({nm, ".state"}, state, e.st);
    chk({nm, ".locked"}, locked, e.lk);
    chk({nm, ".err_pulse"}, err_pulse, e.pl);
    chk({nm, ".err_cnt"}, err_cnt, e.c16);
    chk({nm, ".err_cnt4"}, err_cnt4, e.c4);
    clr          = 1'b0;
    sample_valid = 1'b0;
  endtask

  // one valid sample while locked; inv flips the bit on the wire
  task automatic lsamp(input logic inv, input logic c, input string nm);
    logic b;
    logic loss;
    next_bit(b);
    b    = b ^ inv;
    loss = 1'b0;
    if (inv) begin
      werr++;
      if (werr == 4) loss = 1'b1;
    end
    if (loss) begin
      wpos = 0;
      werr = 0;
      step(1'b1, b, c, ST_SEED, 1'b0, 1'b1, nm);
    end else begin
      if (wpos == 31) begin
        wpos = 0;
        werr = 0;
      end else begin
        wpos++;
      end
      step(1'b1, b, c, ST_LOCK, 1'b1, inv, nm);
    end
  endtask

  task automatic align();
    while (wpos != 0) lsamp(1'b0, 1'b0, "align");
  endtask

  // from SEED with s cleared: lock exactly on the 15th valid sample, gaps anywhere before it
  task automatic acquire(input int gaps, input string nm);
    logic b;
    int   left;
    left = gaps;
    for (int k = 0; k < 15; k++) begin
      while (left > 0 && (k == 14 || $urandom_range(0, 3) == 0)) begin
        step(1'b0, 1'b0, 1'b0, ST_SEED, 1'b0, 1'b0, {nm, ".gap"});
        left--;
      end
      next_bit(b);
      step(1'b1, b, 1'b0, (k == 14) ? ST_LOCK : ST_SEED, k == 14, 1'b0, nm);
    end
    wpos = 0;
    werr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    logic b;
    logic got;
    int   n;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_IDLE};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, ST_SEED};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, ST_SEED};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, ST_IDLE};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_SEED};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; sample_valid = 1'b0; sample_in = 1'b0;
    #12;
    chk("rst.state", state, ST_IDLE);
    chk("rst.locked", locked, 1'b0);
    chk("rst.err_pulse", err_pulse, 1'b0);
    chk("rst.err_cnt", err_cnt, 0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en;
      step(tbl[i].v, tbl[i].b, tbl[i].clr, tbl[i].st, 1'b0, 1'b0, "tbl");
    end

    // clean acquisition, then a long error-free run
    en = 1'b1;
    step(1'b0, 1'b0, 1'b0, ST_SEED, 1'b0, 1'b0, "enter_seed");
    acquire(0, "acq");
    for (int i = 0; i < 500; i++) lsamp(1'b0, 1'b0, "clean");

    // single error: one pulse, lock held
    lsamp(1'b1, 1'b0, "single_err");
    for (int i = 0; i < 40; i++) lsamp(1'b0, 1'b0, "post_single");

    // four errors in one window force loss, then relock in 15 samples
    align();
    for (int p = 0; p < 14; p++) lsamp(p == 2 || p == 5 || p == 9 || p == 13, 1'b0, "burst");
    chk("loss.err_cnt", err_cnt, 5);
    acquire(0, "relock");

    // 3 + 1 errors split across a window boundary keep lock
    align();
    for (int p = 0; p < 32; p++) lsamp(p == 3 || p == 10 || p == 20, 1'b0, "split_a");
    lsamp(1'b0, 1'b0, "split_b");
    lsamp(1'b1, 1'b0, "split_b");
    chk("split.locked", locked, 1'b1);

    // re-acquire with three idle gaps
    en = 1'b0;
    step(1'b1, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0, "en_off");
    en = 1'b1;
    step(1'b0, 1'b0, 1'b0, ST_SEED, 1'b0, 1'b0, "en_on");
    acquire(3, "acq_gaps");

    // all-zero stream never locks; a real stream afterwards does within 15
    en = 1'b0;
    step(1'b1, 1'b0, 1'b0, ST_IDLE, 1'b0, 1'b0, "en_off2");
    en = 1'b1;
    step(1'b0, 1'b0, 1'b0, ST_SEED, 1'b0, 1'b0, "en_on2");
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, ST_SEED, 1'b0, 1'b0, "zeros");
    got = 1'b0;
    n   = 0;
    while (!got && n < 15) begin
      next_bit(b);
      sample_valid = 1'b1;
      sample_in    = b;
      @(posedge clk);
      #1;
      n++;
      got = locked;
    end
    sample_valid = 1'b0;
    chk("zero_relock.locked", got, 1'b1);
    chk("zero_relock.state", state, ST_LOCK);
    chk("zero_relock.err_cnt", err_cnt, exp16);
    wpos = 0;
    werr = 0;

    // 20 isolated errors, one per window: the 4-bit counter pins at 15
    for (int i = 0; i < 20; i++) begin
      align();
      lsamp(1'b1, 1'b0, "sat");
    end
    chk("sat.err_cnt4", err_cnt4, 15);
    chk("sat.err_cnt", err_cnt, 29);

    // clr against a coincident error
    align();
    lsamp(1'b1, 1'b1, "clr_err");
    for (int i = 0; i < 5; i++) lsamp(1'b0, 1'b0, "post_clr");
    lsamp(1'b1, 1'b0, "pre_rst");

    // async reset mid-stream while locked
    #3 rst_n = 1'b0;
    #1;
    chk("arst.state", state, ST_IDLE);
    chk("arst.locked", locked, 1'b0);
    chk("arst.err_pulse", err_pulse, 1'b0);
    chk("arst.err_cnt", err_cnt, 0);
    chk("arst.err_cnt4", err_cnt4, 0);
    exp16 = 0;
    exp4  = 0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, ST_IDLE, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_capture_checker.md
Name: prbs_capture_checker

Overview:
- Downstream consumer of a capture flop on the launch/buffer-chain/capture path; receives one captured bit per valid cycle.
- Self-synchronises a PRBS model to the incoming stream, then checks every bit, counting mismatches.
- Declares loss of lock on an error burst and re-seeds automatically.
- Used as the on-chip observer that verifies the launch path after repair/resize.

Parameters:
- LFSR_W, 7, PRBS register width.
- TAPS, 7'b1100000, feedback mask over s[LFSR_W-1:0] (default PRBS7, x^7+x^6+1).
- LOCK_CNT, 8, consecutive predicted matches required to lock.
- WINDOW, 32, valid samples per loss-detection window.
- LOSS_THRESH, 4, mismatches within one window that force loss of lock.
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  checker enable.
- clr  input  1  synchronous clear of err_cnt.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_in  input  1  captured data bit.
- locked  output  1  checker locked to stream.
- err_pulse  output  1  one-cycle pulse per mismatch while locked.
- err_cnt  output  ERR_W  saturating mismatch count.
- state  output  2  00 IDLE, 01 SEED, 10 LOCKED.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, locked=0, err_pulse=0, err_cnt=0, s=0, fill/match/window counters=0.
- All outputs are registered. Effects of a sample at edge N are visible after edge N.
- Cycles with sample_valid=0 do not advance s or any counter. err_pulse=0 in those cycles.
- Register s: s[0] is the newest bit. predicted = XOR-reduce(s & TAPS).
- IDLE: when en=1, go to SEED; clear s, fill and match counters.
- SEED:
  - Each valid sample shifts into s; fill counts to LFSR_W and saturates.
  - Once fill=LFSR_W, each sample is compared with predicted before the shift.
  - A match increments match, but only if s!=0. All-zero s never counts toward lock.
  - A mismatch clears match.
  - When match reaches LOCK_CNT, go to LOCKED and set locked=1.
  - Mismatches in SEED never touch err_cnt or err_pulse.
- LOCKED:
  - s free-runs on its own feedback: shift in predicted, not sample_in.
  - On a mismatch: err_pulse=1 for one cycle; err_cnt+1, saturating at all-ones; window error count +1.
  - The window sample counter wraps every WINDOW valid samples; window error count then resets to 0.
  - When window errors reach LOSS_THRESH: go to SEED, locked=0, clear fill/match/window counters and s. The triggering sample is discarded.
- en=0 in any state: IDLE on the next edge; locked=0, err_pulse=0; err_cnt held.
- clr=1: err_cnt=0 on the next edge. clr has priority over a simultaneous increment; that err_pulse still fires.
- Clean relock latency from SEED entry: LFSR_W+LOCK_CNT valid samples (15 by default).

Test Plan:
- Assert rst_n=0 mid-stream while locked -> immediately locked=0, err_cnt=0, err_pulse=0, state=00; after release with en=0 the state stays 00.
- en=1, sample_valid=1, clean PRBS7 from seed 7'h7F -> locked=1 after the 15th sample. err_cnt=0 over 500 samples. Inserting 3 random sample_valid=0 gaps delays lock by exactly 3 cycles.
- Locked, invert one bit -> err_pulse high exactly one cycle, err_cnt=1, locked stays 1, later bits match with no further errors.
- Locked, invert 4 bits within 32 samples -> locked=0 after the 4th, state=01, err_cnt=4. Relock after exactly 15 further clean samples. Also invert 3 bits in one window and 1 in the next -> no loss of lock.
- All-zero input for 200 samples -> locked never asserts, err_cnt=0. Then a clean PRBS7 stream -> lock within 15 samples.
- ERR_W=4, inject 20 isolated errors, each in a separate window -> err_cnt saturates at 15. clr coincident with an error -> err_cnt=0, err_pulse=1 that cycle.
